// File: rtl/depth_frame_sequencer.sv
// depth_frame_sequencer: sweeps a clear pass over the depth buffer, then forwards raster beats with depth test.
// Defining DEPTH_FRAME_PIXEL_COUNT_EN adds a saturating 32-bit accepted-beat counter on pixel_count.
module depth_frame_sequencer #(
  parameter int          FB_WIDTH    = 160,
  parameter int          FB_HEIGHT   = 120,
  parameter logic [31:0] CLEAR_DEPTH = 32'h7FFF_FFFF,
  parameter int          DB_LATENCY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [15:0] clear_color,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [15:0] r_color,
  input  logic [31:0] r_depth,
  input  logic [15:0] r_x,
  input  logic [15:0] r_y,
  input  logic        r_last,
  output logic        db_valid,
  output logic        db_compare_depth,
  output logic [15:0] db_color,
  output logic [31:0] db_depth,
  output logic [15:0] db_x,
  output logic [15:0] db_y,
  output logic        busy,
  output logic        clearing,
  output logic        frame_done
`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
  ,
  output logic [31:0] pixel_count
`endif
);

  localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam int DW = (DB_LATENCY > 1) ? $clog2(DB_LATENCY + 1) : 1;
  localparam logic [XW-1:0] X_LAST     = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(FB_HEIGHT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DB_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, DRAIN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            sweep_last;
  logic            drain_last;
  logic            accept;

  assign sweep_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign drain_last = (drain_cnt == DRAIN_LAST);
  assign accept     = r_valid && (state == DRAW);

  assign r_ready    = (state == DRAW);
  assign busy       = (state != IDLE);
  assign clearing   = (state == CLEAR);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = CLEAR;
      CLEAR:   if (sweep_last) state_next = DRAW;
      DRAW:    if (accept && r_last) state_next = DRAIN;
      DRAIN:   if (drain_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sweep counters wrap to (0,0) on the final clear coordinate so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == CLEAR) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) drain_cnt <= '0;
    else                       drain_cnt <= drain_cnt + 1'b1;
  end

  // The state alone selects the db source, so clear writes and raster beats can never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_valid         <= 1'b0;
      db_compare_depth <= 1'b0;
      db_color         <= '0;
      db_depth         <= '0;
      db_x             <= '0;
      db_y             <= '0;
    end else if (state == CLEAR) begin
      db_valid         <= 1'b1;
      db_compare_depth <= 1'b0;
      db_color         <= clear_color;
      db_depth         <= CLEAR_DEPTH;
      db_x             <= 16'(x_cnt);
      db_y             <= 16'(y_cnt);
    end else if (accept) begin
      db_valid         <= 1'b1;
      db_compare_depth <= 1'b1;
      db_color         <= r_color;
      db_depth         <= r_depth;
      db_x             <= r_x;
      db_y             <= r_y;
    end else begin
      db_valid         <= 1'b0;
      db_compare_depth <= 1'b0;
      db_color         <= '0;
      db_depth         <= '0;
      db_x             <= '0;
      db_y             <= '0;
    end
  end

`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                pixel_count <= '0;
    else if (state == IDLE && frame_start)  pixel_count <= '0;
    else if (accept && pixel_count != '1)   pixel_count <= pixel_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_depth_frame_sequencer.sv
// Directed self-checking bench for depth_frame_sequencer with a 4x2 framebuffer and DB_LATENCY=3.
// Build with DEPTH_FRAME_PIXEL_COUNT_EN defined to also check pixel_count.
module tb_depth_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [15:0] clear_color;
  logic        r_valid;
  logic        r_ready;
  logic [15:0] r_color;
  logic [31:0] r_depth;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        r_last;
  logic        db_valid;
  logic        db_compare_depth;
  logic [15:0] db_color;
  logic [31:0] db_depth;
  logic [15:0] db_x;
  logic [15:0] db_y;
  logic        busy;
  logic        clearing;
  logic        frame_done;
`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
  logic [31:0] pixel_count;
`endif

  int checks = 0;
  int errors = 0;

  depth_frame_sequencer #(
    .FB_WIDTH(4),
    .FB_HEIGHT(2),
    .CLEAR_DEPTH(32'h7FFF_FFFF),
    .DB_LATENCY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .clear_color(clear_color),
    .r_valid(r_valid),
    .r_ready(r_ready),
    .r_color(r_color),
    .r_depth(r_depth),
    .r_x(r_x),
    .r_y(r_y),
    .r_last(r_last),
    .db_valid(db_valid),
    .db_compare_depth(db_compare_depth),
    .db_color(db_color),
    .db_depth(db_depth),
    .db_x(db_x),
    .db_y(db_y),
    .busy(busy),
    .clearing(clearing),
    .frame_done(frame_done)
`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
    ,
    .pixel_count(pixel_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic last, input logic [15:0] col,
                               input logic [31:0] dep, input logic [15:0] x, input logic [15:0] y);
    r_valid = v;
    r_last  = last;
    r_color = col;
    r_depth = dep;
    r_x     = x;
    r_y     = y;
  endtask

  // Pulse frame_start from IDLE and check all 8 clear writes; optionally re-pulse frame_start mid-sweep.
  task automatic runSweep(input logic [15:0] col, input int repulse_at);
    clear_color = col;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("sweep_start_clearing", {31'd0, clearing}, 32'd1);
    checkOutput("sweep_start_db_valid", {31'd0, db_valid}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      frame_start = (k == repulse_at);
      tick();
      frame_start = 1'b0;
      checkOutput("clr_valid", {31'd0, db_valid}, 32'd1);
      checkOutput("clr_cmp", {31'd0, db_compare_depth}, 32'd0);
      checkOutput("clr_x", {16'd0, db_x}, k % 4);
      checkOutput("clr_y", {16'd0, db_y}, k / 4);
      checkOutput("clr_depth", db_depth, 32'h7FFF_FFFF);
      checkOutput("clr_color", {16'd0, db_color}, {16'd0, col});
      checkOutput("clr_r_ready", {31'd0, r_ready}, (k == 7) ? 32'd1 : 32'd0);
      checkOutput("clr_clearing", {31'd0, clearing}, (k == 7) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic checkDrain(input logic [31:0] exp_count);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("drain_frame_done", {31'd0, frame_done}, 32'd0);
      checkOutput("drain_busy", {31'd0, busy}, 32'd1);
      checkOutput("drain_db_valid", {31'd0, db_valid}, 32'd0);
      checkOutput("drain_db_x", {16'd0, db_x}, 32'd0);
    end
    tick();
    checkOutput("done_frame_done", {31'd0, frame_done}, 32'd1);
`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
    checkOutput("done_pixel_count", pixel_count, exp_count);
`endif
    tick();
    checkOutput("idle_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
    checkOutput("idle_pixel_count_hold", pixel_count, exp_count);
`else
    if (exp_count == 32'hFFFF_FFFF) $display("[TB] unexpected count argument");
`endif
  endtask

  // In DRAW: ignored frame_start and lone r_last, then n back-to-back beats, the last flagged r_last.
  task automatic drawBeats(input int n);
    frame_start = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0, 32'h0, 16'h0, 16'h0);
    tick();
    frame_start = 1'b0;
    checkOutput("draw_no_restart", {31'd0, clearing}, 32'd0);
    checkOutput("draw_lone_last_ready", {31'd0, r_ready}, 32'd1);
    checkOutput("draw_idle_db_valid", {31'd0, db_valid}, 32'd0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, (i == n - 1), 16'hA000 + 16'(i), 32'h0001_0000 * (i + 1),
                    16'(i + 1), 16'(2 * i));
      checkOutput("beat_r_ready", {31'd0, r_ready}, 32'd1);
      tick();
      checkOutput("beat_valid", {31'd0, db_valid}, 32'd1);
      checkOutput("beat_cmp", {31'd0, db_compare_depth}, 32'd1);
      checkOutput("beat_color", {16'd0, db_color}, 32'h0000_A000 + i);
      checkOutput("beat_depth", db_depth, 32'h0001_0000 * (i + 1));
      checkOutput("beat_x", {16'd0, db_x}, i + 1);
      checkOutput("beat_y", {16'd0, db_y}, 2 * i);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
    checkOutput("drain_r_ready", {31'd0, r_ready}, 32'd0);
    checkOutput("drain_entry_busy", {31'd0, busy}, 32'd1);
    checkOutput("drain_entry_done", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    clear_color = 16'h0;
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
    tick();
    tick();
    checkOutput("rst_db_valid", {31'd0, db_valid}, 32'd0);
    checkOutput("rst_db_depth", db_depth, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_r_ready", {31'd0, r_ready}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
    checkOutput("rst_pixel_count", pixel_count, 32'd0);
`endif
    rst = 1'b0;
    tick();

    $display("[TB] frame A: clear sweep with re-pulse, then 3 beats");
    runSweep(16'h0F0F, 3);
    drawBeats(3);
    checkDrain(32'd3);

    $display("[TB] frame B: reset on the 4th clear cycle");
    clear_color = 16'h1234;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("abort_pre_db_valid", {31'd0, db_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_db_valid", {31'd0, db_valid}, 32'd0);
    checkOutput("abort_db_x", {16'd0, db_x}, 32'd0);
    checkOutput("abort_db_color", {16'd0, db_color}, 32'd0);
    checkOutput("abort_db_depth", db_depth, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_clearing", {31'd0, clearing}, 32'd0);
    checkOutput("abort_frame_done", {31'd0, frame_done}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("abort_no_done", {31'd0, frame_done}, 32'd0);
    end

    $display("[TB] frame C: raster beat held during clear, accepted on first DRAW cycle");
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 32'h0000_1234, 16'd7, 16'd5);
    runSweep(16'h5A5A, -1);
    tick();
    checkOutput("early_beat_valid", {31'd0, db_valid}, 32'd1);
    checkOutput("early_beat_cmp", {31'd0, db_compare_depth}, 32'd1);
    checkOutput("early_beat_color", {16'd0, db_color}, 32'h0000_BEEF);
    checkOutput("early_beat_depth", db_depth, 32'h0000_1234);
    checkOutput("early_beat_x", {16'd0, db_x}, 32'd7);
    checkOutput("early_beat_y", {16'd0, db_y}, 32'd5);
    checkOutput("early_beat_drain", {31'd0, r_ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
    checkDrain(32'd1);

    $display("[TB] frame D: 5 beats");
    runSweep(16'hFFFF, -1);
    drawBeats(5);
    checkDrain(32'd5);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("restart_clearing", {31'd0, clearing}, 32'd1);
`ifdef DEPTH_FRAME_PIXEL_COUNT_EN
    checkOutput("restart_pixel_count", pixel_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
